// File: rtl/cpu_trap_pkg.sv
// Shared definitions for the M-mode trap unit: privilege levels, cause codes, CSR addresses,
// trap FSM encoding and the excause -> mcause mapping.
package cpu_trap_pkg;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_M = 2'd3;

  // Codes driven by the exception-detection stage
  localparam logic [1:0] EXCAUSE_MISALIGN = 2'd0;
  localparam logic [1:0] EXCAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] EXCAUSE_ECALL    = 2'd2;
  localparam logic [1:0] EXCAUSE_EBREAK   = 2'd3;

  // Architectural mcause values
  localparam logic [3:0] MCAUSE_MISALIGN   = 4'd0;
  localparam logic [3:0] MCAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] MCAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] MCAUSE_ECALL_U    = 4'd8;
  localparam logic [3:0] MCAUSE_ECALL_M    = 4'd11;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;

  typedef enum logic [1:0] {
    StRun,
    StEnter,
    StReturn,
    StRedirect
  } trap_state_e;

  // ecall splits by the privilege it was issued from
  function automatic logic [3:0] map_mcause(input logic [1:0] excause, input logic [1:0] priv);
    logic [3:0] cause;
    case (excause)
      EXCAUSE_MISALIGN: cause = MCAUSE_MISALIGN;
      EXCAUSE_ILLEGAL:  cause = MCAUSE_ILLEGAL;
      EXCAUSE_ECALL:    cause = (priv == PRIV_U) ? MCAUSE_ECALL_U : MCAUSE_ECALL_M;
      default:          cause = MCAUSE_BREAKPOINT;
    endcase
    return cause;
  endfunction

  // Only U and M exist; anything other than M collapses to U
  function automatic logic [1:0] warl_mpp(input logic [1:0] value);
    return (value == PRIV_M) ? PRIV_M : PRIV_U;
  endfunction

endpackage

// File: rtl/cpu_trap_csrs.sv
// M-mode trap CSR storage: mstatus (MIE/MPIE/MPP), mtvec, mscratch, mepc, mcause and,
// with CPU_TRAP_MTVAL_EN defined, mtval. Handles CSR reads, WARL write masking and the
// field updates for trap entry and return.
module cpu_trap_csrs
  import cpu_trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trap_enter_i,
  input  logic            trap_return_i,
  input  logic [3:0]      trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
`ifdef CPU_TRAP_MTVAL_EN
  input  logic [XLEN-1:0] trap_tval_i,
`endif
  input  logic [1:0]      priv_i,
  input  logic [11:0]     csr_addr_i,
  input  logic            csr_we_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_hit_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [1:0]      mpp_o
);

  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [1:0]      mpp_q, mpp_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CPU_TRAP_MTVAL_EN
  logic [XLEN-1:0] mtval_q, mtval_d;
`endif

  // Next-state: software writes first, trap entry/return override the fields they own
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mpp_d      = mpp_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef CPU_TRAP_MTVAL_EN
    mtval_d    = mtval_q;
`endif
    if (csr_we_i) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata_i[MSTATUS_MIE_BIT];
          mpie_d = csr_wdata_i[MSTATUS_MPIE_BIT];
          mpp_d  = warl_mpp(csr_wdata_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        end
        CSR_MTVEC:    mtvec_d    = csr_wdata_i & AlignMask;
        CSR_MSCRATCH: mscratch_d = csr_wdata_i;
        CSR_MEPC:     mepc_d     = csr_wdata_i & AlignMask;
        CSR_MCAUSE:   mcause_d   = csr_wdata_i;
`ifdef CPU_TRAP_MTVAL_EN
        CSR_MTVAL:    mtval_d    = csr_wdata_i;
`endif
        default: ;
      endcase
    end
    if (trap_enter_i) begin
      mepc_d   = trap_pc_i & AlignMask;
      mcause_d = XLEN'(trap_cause_i);
      mpp_d    = priv_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
`ifdef CPU_TRAP_MTVAL_EN
      mtval_d  = trap_tval_i;
`endif
    end else if (trap_return_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      mpp_d  = PRIV_U;
    end
  end

  // CSR state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= PRIV_U;
      mtvec_q    <= MTVEC_RESET & AlignMask;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
`ifdef CPU_TRAP_MTVAL_EN
      mtval_q    <= '0;
`endif
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
`ifdef CPU_TRAP_MTVAL_EN
      mtval_q    <= mtval_d;
`endif
    end
  end

  // Combinational read mux; unimplemented mstatus bits and unmapped addresses read 0
  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MSTATUS_MIE_BIT]                = mie_q;
        csr_rdata_o[MSTATUS_MPIE_BIT]               = mpie_q;
        csr_rdata_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
      end
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
`ifdef CPU_TRAP_MTVAL_EN
      CSR_MTVAL:    csr_rdata_o = mtval_q;
`endif
      default:      csr_hit_o   = 1'b0;
    endcase
  end

  assign mepc_o  = mepc_q;
  assign mtvec_o = mtvec_q;
  assign mpp_o   = mpp_q;

endmodule

// File: rtl/cpu_trap_unit.sv
// M-mode trap entry/return unit. Owns the privilege register and the trap FSM
// (RUN -> ENTER/RETURN -> REDIRECT -> RUN) and drives the fetch redirect handshake.
// Optional feature: define CPU_TRAP_MTVAL_EN to add the tval input and the mtval CSR.
module cpu_trap_unit
  import cpu_trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exception,
  input  logic [1:0]      excause,
  input  logic            mret,
  input  logic [XLEN-1:0] instr_pc,
`ifdef CPU_TRAP_MTVAL_EN
  input  logic [XLEN-1:0] tval,
`endif
  input  logic [11:0]     csr_addr,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  output logic [1:0]      priv,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  trap_state_e     state_q, state_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            in_run;
  logic            take_trap;
  logic            take_return;
  logic            csr_we_run;
  logic [3:0]      trap_cause;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mtvec;
  logic [1:0]      mpp;

  // Events are only accepted in RUN; exception wins over a same-cycle mret
  assign in_run      = (state_q == StRun);
  assign take_trap   = in_run & exception;
  assign take_return = in_run & mret & ~exception;
  assign csr_we_run  = in_run & csr_we & ~exception;
  assign trap_cause  = map_mcause(excause, priv_q);

`ifdef CPU_TRAP_MTVAL_EN
  logic [XLEN-1:0] trap_tval;
  assign trap_tval = ((excause == EXCAUSE_MISALIGN) || (excause == EXCAUSE_ILLEGAL)) ? tval : '0;
`endif

  cpu_trap_csrs #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csrs (
    .clk_i         (clk),
    .rst_i         (rst),
    .trap_enter_i  (take_trap),
    .trap_return_i (take_return),
    .trap_cause_i  (trap_cause),
    .trap_pc_i     (instr_pc),
`ifdef CPU_TRAP_MTVAL_EN
    .trap_tval_i   (trap_tval),
`endif
    .priv_i        (priv_q),
    .csr_addr_i    (csr_addr),
    .csr_we_i      (csr_we_run),
    .csr_wdata_i   (csr_wdata),
    .csr_rdata_o   (csr_rdata),
    .csr_hit_o     (csr_hit),
    .mepc_o        (mepc),
    .mtvec_o       (mtvec),
    .mpp_o         (mpp)
  );

  // State, privilege and redirect target registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      priv_q        <= PRIV_M;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      priv_q        <= priv_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next-state: mtvec and mepc are stored aligned, so they are used as targets directly
  always_comb begin
    state_d       = state_q;
    priv_d        = priv_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      StRun: begin
        if (take_trap) begin
          state_d = StEnter;
          priv_d  = PRIV_M;
        end else if (take_return) begin
          state_d = StReturn;
          priv_d  = mpp;
        end
      end
      StEnter: begin
        state_d       = StRedirect;
        redirect_pc_d = mtvec;
      end
      StReturn: begin
        state_d       = StRedirect;
        redirect_pc_d = mepc;
      end
      StRedirect: begin
        if (redirect_ready) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs: stall whenever not in RUN, flush pulses in the accepting cycle
  always_comb begin
    stall          = (state_q != StRun);
    flush          = ~rst & (take_trap | take_return);
    redirect_valid = (state_q == StRedirect);
    redirect_pc    = redirect_pc_q;
    priv           = priv_q;
  end

endmodule

// File: tb/tb_cpu_trap_unit.sv
// Directed bench for cpu_trap_unit: a table of CSR write/read vectors followed by
// hand-written trap entry, trap return, handshake-hold and reset-in-redirect sequences.
module tb_cpu_trap_unit;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] MTVEC_RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception = 1'b0;
  logic [1:0]  excause = 2'd0;
  logic        mret = 1'b0;
  logic [31:0] instr_pc = '0;
  logic [11:0] csr_addr = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic        redirect_ready = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic [1:0]  priv;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef CPU_TRAP_MTVAL_EN
  logic [31:0] tval = '0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_trap_unit #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .exception      (exception),
    .excause        (excause),
    .mret           (mret),
    .instr_pc       (instr_pc),
`ifdef CPU_TRAP_MTVAL_EN
    .tval           (tval),
`endif
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_hit        (csr_hit),
    .priv           (priv),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    csr_addr  = addr;
    csr_wdata = data;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic csr_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  // Drive one trap/mret event from RUN and follow it through the redirect handshake,
  // holding redirect_ready low for 'hold' extra REDIRECT cycles.
  task automatic trap_seq(input string name, input logic exc, input logic [1:0] cause,
                          input logic m, input logic [31:0] pc, input logic [31:0] exp_pc,
                          input int hold);
    exception = exc;
    excause   = cause;
    mret      = m;
    instr_pc  = pc;
    #1;
    check({name, " flush"}, 32'(flush), 32'd1);
    check({name, " stall0"}, 32'(stall), 32'd0);
    tick();
    exception = 1'b0;
    mret      = 1'b0;
    #1;
    check({name, " stall1"}, 32'(stall), 32'd1);
    check({name, " flush_off"}, 32'(flush), 32'd0);
    check({name, " valid_early"}, 32'(redirect_valid), 32'd0);
    tick();
    check({name, " valid"}, 32'(redirect_valid), 32'd1);
    check({name, " rpc"}, redirect_pc, exp_pc);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({name, " hold_valid"}, 32'(redirect_valid), 32'd1);
      check({name, " hold_rpc"}, redirect_pc, exp_pc);
    end
    redirect_ready = 1'b1;
    #1;
    tick();
    redirect_ready = 1'b0;
    #1;
    check({name, " valid_done"}, 32'(redirect_valid), 32'd0);
    check({name, " stall_done"}, 32'(stall), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 12'h300, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{1'b0, 12'h305, 32'h0, MTVEC_RV, 1'b1};
    vecs[2]  = '{1'b0, 12'h341, 32'h0, 32'h0, 1'b1};
    vecs[3]  = '{1'b0, 12'h342, 32'h0, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 12'h340, 32'h0, 32'h0, 1'b1};
    vecs[5]  = '{1'b1, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[6]  = '{1'b1, 12'h305, 32'h0000_0803, 32'h0000_0800, 1'b1};
    vecs[7]  = '{1'b1, 12'h341, 32'h0000_0107, 32'h0000_0104, 1'b1};
    vecs[8]  = '{1'b1, 12'h342, 32'h0000_0005, 32'h0000_0005, 1'b1};
    vecs[9]  = '{1'b1, 12'h300, 32'h0000_1888, 32'h0000_1888, 1'b1};
    vecs[10] = '{1'b1, 12'h300, 32'h0000_0800, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 12'h300, 32'h0000_1000, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b1};
    vecs[13] = '{1'b1, 12'h123, 32'h0000_FFFF, 32'h0000_0000, 1'b0};
`ifdef CPU_TRAP_MTVAL_EN
    vecs[14] = '{1'b1, 12'h343, 32'h0000_0055, 32'h0000_0055, 1'b1};
`else
    vecs[14] = '{1'b1, 12'h343, 32'h0000_0055, 32'h0000_0000, 1'b0};
`endif
    vecs[15] = '{1'b1, 12'h300, 32'h0000_0000, 32'h0000_0000, 1'b1};

    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset priv", 32'(priv), 32'd3);
    check("reset valid", 32'(redirect_valid), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset rpc", redirect_pc, 32'd0);

    // CSR table: optional write, then read back
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) csr_wr(vecs[i].addr, vecs[i].wdata);
      csr_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d hit", i), 32'(csr_hit), 32'(vecs[i].exp_hit));
    end

    // mret from M with MPP=0 drops to U
    csr_wr(12'h341, 32'h0000_0200);
    trap_seq("mret_to_u", 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_0200, 0);
    check("mret_to_u priv", 32'(priv), 32'd0);
    csr_chk("mret_to_u mstatus", 12'h300, 32'h0000_0080);

    // ecall from U, redirect held for 5 cycles
    csr_wr(12'h300, 32'h0000_0000);
    trap_seq("ecall_u", 1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h0000_0800, 5);
    csr_chk("ecall_u mcause", 12'h342, 32'd8);
    csr_chk("ecall_u mepc", 12'h341, 32'h0000_0100);
    csr_chk("ecall_u mstatus", 12'h300, 32'h0000_0000);
    check("ecall_u priv", 32'(priv), 32'd3);

    // mret with MPP=0, MPIE=1
    csr_wr(12'h300, 32'h0000_0080);
    csr_wr(12'h341, 32'h0000_0104);
    trap_seq("mret_mpie", 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_0104, 0);
    check("mret_mpie priv", 32'(priv), 32'd0);
    csr_chk("mret_mpie mstatus", 12'h300, 32'h0000_0088);

    // exception and mret together: trap only
`ifdef CPU_TRAP_MTVAL_EN
    tval = 32'h0000_0BAD;
`endif
    trap_seq("exc_mret", 1'b1, 2'd1, 1'b1, 32'h0000_0204, 32'h0000_0800, 0);
    csr_chk("exc_mret mcause", 12'h342, 32'd2);
    csr_chk("exc_mret mepc", 12'h341, 32'h0000_0204);
    csr_chk("exc_mret mstatus", 12'h300, 32'h0000_0080);
    check("exc_mret priv", 32'(priv), 32'd3);
`ifdef CPU_TRAP_MTVAL_EN
    csr_chk("exc_mret mtval", 12'h343, 32'h0000_0BAD);
`endif

    // ecall from M; events and CSR writes during ENTER must be ignored
    exception = 1'b1;
    excause   = 2'd2;
    instr_pc  = 32'h0000_0300;
    tick();
    instr_pc  = 32'h0000_0500;
    mret      = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = 12'h340;
    csr_wdata = 32'h0000_1234;
    tick();
    exception = 1'b0;
    mret      = 1'b0;
    csr_we    = 1'b0;
    #1;
    check("ecall_m valid", 32'(redirect_valid), 32'd1);
    check("ecall_m rpc", redirect_pc, 32'h0000_0800);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    #1;
    check("ecall_m stall_done", 32'(stall), 32'd0);
    csr_chk("ecall_m mcause", 12'h342, 32'd11);
    csr_chk("ecall_m mepc", 12'h341, 32'h0000_0300);
    csr_chk("ecall_m mscratch", 12'h340, 32'hDEAD_BEEF);
    csr_chk("ecall_m mstatus", 12'h300, 32'h0000_1800);

    // remaining cause mappings from M
    trap_seq("ebreak", 1'b1, 2'd3, 1'b0, 32'h0000_0040, 32'h0000_0800, 0);
    csr_chk("ebreak mcause", 12'h342, 32'd3);
    trap_seq("misalign", 1'b1, 2'd0, 1'b0, 32'h0000_0042, 32'h0000_0800, 0);
    csr_chk("misalign mcause", 12'h342, 32'd0);
    csr_chk("misalign mepc", 12'h341, 32'h0000_0040);

    // reset while a return-to-U redirect is pending
    csr_wr(12'h300, 32'h0000_0000);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    tick();
    check("rst_mid valid_before", 32'(redirect_valid), 32'd1);
    check("rst_mid priv_before", 32'(priv), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid valid", 32'(redirect_valid), 32'd0);
    check("rst_mid stall", 32'(stall), 32'd0);
    check("rst_mid priv", 32'(priv), 32'd3);
    csr_chk("rst_mid mcause", 12'h342, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
